// File: rtl/rx_seq_pkg.sv
// rx_seq_pkg
//   Shared types and helpers for the RX frame sequencer.
//   - state_t        : sequencer FSM states
//   - frame_result_t : per-frame outcome, also used to index the counter bank
//   - cnt_width()    : bit width needed to hold values 0..max_val
package rx_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GOOD = 2'd0,
        ERR  = 2'd1,
        DROP = 2'd2
    } frame_result_t;

    // Width of a counter that must reach max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk   - clock
//     rst   - asynchronous active-high reset, clears count
//     inc   - count up by one (holds at all-ones)
//     clr   - synchronous clear, wins over a same-cycle inc
//     count - current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer
//   Sequences RX frames one at a time from the AXI-Stream FIFO to the header
//   parser: forwards bytes through a single registered stage, truncates frames
//   longer than MAX_LEN, drains frames the parser aborts, inserts an
//   inter-frame gap and keeps saturating good/error/drop counters.
//   Ports:
//     clk, rst                        - clock, async active-high reset
//     enable                          - accept new frames (looked at in IDLE only)
//     s_tdata/s_tvalid/s_tlast/s_tuser/s_tready - FIFO side
//     m_tdata/m_tvalid/m_tlast/m_tuser/m_tready - parser side
//     parser_err                      - parser abort pulse for the current frame
//     cnt_clr                         - synchronous clear of all counters
//     cnt_good/cnt_err/cnt_drop       - per-frame outcome counters
//     busy                            - sequencer is not IDLE
module rx_frame_sequencer #(
    parameter int MAX_LEN    = 1518,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    input  logic             s_tuser,
    output logic             s_tready,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic             m_tuser,
    input  logic             m_tready,
    input  logic             parser_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_err,
    output logic [CNT_W-1:0] cnt_drop,
    output logic             busy
);
    import rx_seq_pkg::*;

    localparam int BCNT_W = cnt_width(MAX_LEN);
    localparam int GCNT_W = cnt_width(255);
    localparam logic [BCNT_W-1:0] LAST_BYTE_IDX = BCNT_W'(MAX_LEN - 1);
    // GAP always lasts at least one cycle, so GAP_CYCLES=0 behaves like 1.
    localparam logic [GCNT_W-1:0] GAP_LAST = GCNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t              state_reg;
    logic [BCNT_W-1:0]   byte_cnt_reg;
    logic [GCNT_W-1:0]   gap_cnt_reg;
    logic                dropped_reg;
    logic [7:0]          m_tdata_reg;
    logic                m_tvalid_reg;
    logic                m_tlast_reg;
    logic                m_tuser_reg;

    logic                out_free;
    logic                s_hs;
    logic                m_hs;
    logic                frame_end;
    logic                truncate;
    logic                abort;
    frame_result_t       frame_res;
    logic [2:0]          inc_vec;
    logic [CNT_W-1:0]    cnt_vec [3];

    // The output register can take a new byte when empty or emptying now.
    assign out_free  = !m_tvalid_reg || m_tready;
    assign s_tready  = ((state_reg == FWD) || (state_reg == DRAIN)) && out_free;
    assign s_hs      = s_tvalid && s_tready;
    assign m_hs      = m_tvalid_reg && m_tready;
    assign frame_end = s_hs && s_tlast;
    assign abort     = (state_reg == FWD) && parser_err;
    // A byte that is both number MAX_LEN and tlast is a normal end.
    assign truncate  = (state_reg == FWD) && s_hs && !s_tlast &&
                       (byte_cnt_reg == LAST_BYTE_IDX);

    always_comb begin
        frame_res = GOOD;
        if (dropped_reg || abort) begin
            frame_res = DROP;
        end else if (s_tuser) begin
            frame_res = ERR;
        end
    end

    // Exactly one counter steps on the cycle the FIFO tlast is consumed.
    always_comb begin
        inc_vec = '0;
        if (frame_end) begin
            inc_vec[frame_res] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            dropped_reg  <= 1'b0;
            m_tdata_reg  <= '0;
            m_tvalid_reg <= 1'b0;
            m_tlast_reg  <= 1'b0;
            m_tuser_reg  <= 1'b0;
        end else begin
            if (m_hs) begin
                m_tvalid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (enable && s_tvalid) begin
                        state_reg    <= FWD;
                        byte_cnt_reg <= '0;
                        dropped_reg  <= 1'b0;
                    end
                end
                FWD: begin
                    if (s_hs) begin
                        byte_cnt_reg <= byte_cnt_reg + BCNT_W'(1);
                    end
                    // An abort discards the byte accepted in the same cycle.
                    if (s_hs && !abort) begin
                        m_tvalid_reg <= 1'b1;
                        m_tdata_reg  <= s_tdata;
                        m_tlast_reg  <= s_tlast || truncate;
                        m_tuser_reg  <= s_tlast ? s_tuser : truncate;
                    end
                    if (abort) begin
                        m_tvalid_reg <= 1'b0;
                        dropped_reg  <= 1'b1;
                        gap_cnt_reg  <= '0;
                        state_reg    <= frame_end ? GAP : DRAIN;
                    end else if (frame_end) begin
                        gap_cnt_reg  <= '0;
                        state_reg    <= GAP;
                    end else if (truncate) begin
                        dropped_reg  <= 1'b1;
                        state_reg    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (frame_end) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GCNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_vec[gi]),
            .clr   (cnt_clr),
            .count (cnt_vec[gi])
        );
    end

    assign cnt_good = cnt_vec[GOOD];
    assign cnt_err  = cnt_vec[ERR];
    assign cnt_drop = cnt_vec[DROP];
    assign m_tdata  = m_tdata_reg;
    assign m_tvalid = m_tvalid_reg;
    assign m_tlast  = m_tlast_reg;
    assign m_tuser  = m_tuser_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed testbench for rx_frame_sequencer. MAX_LEN=100 so the 100-byte error
// frame also lands exactly on the length limit; CNT_W=4 keeps saturation short.
module tb_rx_frame_sequencer;
    localparam int MAX_LEN    = 100;
    localparam int GAP_CYCLES = 4;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [7:0]       s_tdata = 8'd0;
    logic             s_tvalid = 1'b0;
    logic             s_tlast = 1'b0;
    logic             s_tuser = 1'b0;
    logic             s_tready;
    logic [7:0]       m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tuser;
    logic             m_tready = 1'b0;
    logic             parser_err = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] cnt_good;
    logic [CNT_W-1:0] cnt_err;
    logic [CNT_W-1:0] cnt_drop;
    logic             busy;

    int checks = 0;
    int passed = 0;

    logic [7:0] out_data[$];
    logic       out_last[$];
    logic       out_user[$];
    int         out_cyc[$];
    int         acc_cyc[$];
    int         hold_err;
    int         valid_after_pe;
    int         gap_cnt;
    bit         timed_out;

    always #5 clk = ~clk;

    rx_frame_sequencer #(
        .MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .m_tready(m_tready),
        .parser_err(parser_err), .cnt_clr(cnt_clr),
        .cnt_good(cnt_good), .cnt_err(cnt_err), .cnt_drop(cnt_drop),
        .busy(busy)
    );

    function automatic logic [7:0] pat(input int seed, input int k);
        return 8'((seed + k * 7) & 255);
    endfunction

    // Counts data mismatches and misplaced last/user flags of a forwarded frame
    // whose final forwarded byte index is last_k and final tuser is last_user.
    function automatic int bad_bytes(input int seed, input int last_k, input logic last_user);
        int bad = 0;
        for (int k = 0; k < out_data.size(); k++) begin
            if (out_data[k] !== pat(seed, k)) bad++;
            if (out_last[k] !== (k == last_k)) bad++;
            if (out_user[k] !== ((k == last_k) ? last_user : 1'b0)) bad++;
        end
        return bad;
    endfunction

    // Presents one frame to the FIFO side and records everything seen on the
    // parser side until the sequencer returns to IDLE with nothing pending.
    task automatic run_frame(input int len, input int seed, input logic user,
                             input int pe_at, input bit stall, input bit clr_on_last);
        int sent = 0;
        int cyc = 0;
        bit done_in = 0;
        bit pe_done = 0;
        bit after_pe = 0;
        bit prev_stall = 0;
        logic [7:0] pd = 8'd0;
        logic pl = 1'b0;
        logic pu = 1'b0;
        out_data.delete(); out_last.delete(); out_user.delete();
        out_cyc.delete(); acc_cyc.delete();
        hold_err = 0; valid_after_pe = 0; gap_cnt = 0; timed_out = 0;
        forever begin
            if (cyc >= 2000) begin
                timed_out = 1;
                break;
            end
            m_tready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            cnt_clr  = 1'b0;
            if (!done_in) begin
                s_tvalid = 1'b1;
                s_tdata  = pat(seed, sent);
                s_tlast  = (sent == len - 1);
                s_tuser  = (sent == len - 1) ? user : 1'b0;
            end else begin
                s_tvalid = 1'b0; s_tdata = 8'd0; s_tlast = 1'b0; s_tuser = 1'b0;
            end
            parser_err = (pe_at > 0) && !pe_done && m_tvalid && (out_data.size() == pe_at - 1);
            #1;
            if (clr_on_last && s_tvalid && s_tready && s_tlast) cnt_clr = 1'b1;
            if (prev_stall && (!m_tvalid || m_tdata !== pd || m_tlast !== pl || m_tuser !== pu))
                hold_err++;
            if (after_pe && m_tvalid) valid_after_pe++;
            if (done_in && busy && !s_tready) gap_cnt++;
            if (done_in && !busy && !m_tvalid) break;
            if (m_tvalid && m_tready) begin
                out_data.push_back(m_tdata); out_last.push_back(m_tlast);
                out_user.push_back(m_tuser); out_cyc.push_back(cyc);
            end
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata; pl = m_tlast; pu = m_tuser;
            if (s_tvalid && s_tready) begin
                acc_cyc.push_back(cyc);
                if (s_tlast) done_in = 1;
                sent++;
            end
            if (parser_err) begin
                pe_done = 1;
                after_pe = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; parser_err = 1'b0;
        cnt_clr = 1'b0; m_tready = 1'b1;
        checks++;
        if (timed_out) $display("FAIL frame_timeout: len=%0d sent=%0d got no return to idle, required idle within 2000 cycles", len, sent);
        else passed++;
        $display("frame len=%0d accepted=%0d forwarded=%0d gap=%0d good=%0d err=%0d drop=%0d",
                 len, acc_cyc.size(), out_data.size(), gap_cnt, cnt_good, cnt_err, cnt_drop);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, busy, cnt_good, cnt_err, cnt_drop} !== '0)
            $display("FAIL reset_state: got v=%b l=%b u=%b d=%h rdy=%b busy=%b g=%0d e=%0d dr=%0d, required all 0",
                     m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, busy, cnt_good, cnt_err, cnt_drop);
        else passed++;
        rst = 1'b0; enable = 1'b1; m_tready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat_bad;
        for (int f = 0; f < 2; f++) begin
            run_frame(64, 10 + f, 1'b0, 0, 1'b0, 1'b0);
            checks++;
            if (out_data.size() !== 64) $display("FAIL b2b_len f%0d: got %0d required 64", f, out_data.size());
            else passed++;
            lat_bad = 0;
            for (int k = 0; k < out_cyc.size() && k < acc_cyc.size(); k++)
                if (out_cyc[k] != acc_cyc[k] + 1) lat_bad++;
            checks++;
            if (lat_bad !== 0) $display("FAIL b2b_latency f%0d: got %0d late bytes required 0", f, lat_bad);
            else passed++;
            checks++;
            if (bad_bytes(10 + f, 63, 1'b0) !== 0) $display("FAIL b2b_bytes f%0d: got %0d bad bytes required 0", f, bad_bytes(10 + f, 63, 1'b0));
            else passed++;
            checks++;
            if (gap_cnt !== GAP_CYCLES) $display("FAIL b2b_gap f%0d: got %0d required %0d", f, gap_cnt, GAP_CYCLES);
            else passed++;
        end
        checks++;
        if ({cnt_good, cnt_err, cnt_drop} !== {4'd2, 4'd0, 4'd0})
            $display("FAIL b2b_counters: got g=%0d e=%0d d=%0d required 2/0/0", cnt_good, cnt_err, cnt_drop);
        else passed++;
    endtask

    task automatic test_error_frame();
        run_frame(100, 33, 1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (out_data.size() !== 100) $display("FAIL err_len: got %0d required 100", out_data.size());
        else passed++;
        checks++;
        if (bad_bytes(33, 99, 1'b1) !== 0) $display("FAIL err_bytes: got %0d bad bytes required 0", bad_bytes(33, 99, 1'b1));
        else passed++;
        checks++;
        if ({cnt_good, cnt_err, cnt_drop} !== {4'd2, 4'd1, 4'd0})
            $display("FAIL err_counters: got g=%0d e=%0d d=%0d required 2/1/0", cnt_good, cnt_err, cnt_drop);
        else passed++;
    endtask

    task automatic test_truncate();
        run_frame(120, 50, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (out_data.size() !== 100) $display("FAIL trunc_len: got %0d required 100", out_data.size());
        else passed++;
        checks++;
        if (bad_bytes(50, 99, 1'b1) !== 0) $display("FAIL trunc_bytes: got %0d bad bytes required 0", bad_bytes(50, 99, 1'b1));
        else passed++;
        checks++;
        if (acc_cyc.size() !== 120) $display("FAIL trunc_drained: got %0d accepted required 120", acc_cyc.size());
        else passed++;
        checks++;
        if ({cnt_good, cnt_err, cnt_drop} !== {4'd2, 4'd1, 4'd1})
            $display("FAIL trunc_counters: got g=%0d e=%0d d=%0d required 2/1/1", cnt_good, cnt_err, cnt_drop);
        else passed++;
        run_frame(10, 70, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (out_data.size() !== 10 || bad_bytes(70, 9, 1'b0) !== 0)
            $display("FAIL trunc_next: got %0d bytes with %0d bad required 10 with 0 bad", out_data.size(), bad_bytes(70, 9, 1'b0));
        else passed++;
        checks++;
        if (cnt_good !== 4'd3) $display("FAIL trunc_next_good: got %0d required 3", cnt_good);
        else passed++;
    endtask

    task automatic test_parser_abort();
        run_frame(64, 90, 1'b0, 20, 1'b0, 1'b0);
        checks++;
        if (out_data.size() !== 20 || bad_bytes(90, -1, 1'b0) !== 0)
            $display("FAIL abort_out: got %0d bytes with %0d bad required 20 with 0 bad", out_data.size(), bad_bytes(90, -1, 1'b0));
        else passed++;
        checks++;
        if (valid_after_pe !== 0) $display("FAIL abort_valid: got %0d valid cycles after abort required 0", valid_after_pe);
        else passed++;
        checks++;
        if (acc_cyc.size() !== 64) $display("FAIL abort_drained: got %0d accepted required 64", acc_cyc.size());
        else passed++;
        checks++;
        if (gap_cnt !== GAP_CYCLES) $display("FAIL abort_gap: got %0d required %0d", gap_cnt, GAP_CYCLES);
        else passed++;
        checks++;
        if ({cnt_good, cnt_err, cnt_drop} !== {4'd3, 4'd1, 4'd2})
            $display("FAIL abort_counters: got g=%0d e=%0d d=%0d required 3/1/2", cnt_good, cnt_err, cnt_drop);
        else passed++;
    endtask

    task automatic test_stall();
        run_frame(30, 120, 1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (hold_err !== 0) $display("FAIL stall_hold: got %0d unstable stalled cycles required 0", hold_err);
        else passed++;
        checks++;
        if (out_data.size() !== 30 || bad_bytes(120, 29, 1'b0) !== 0)
            $display("FAIL stall_bytes: got %0d bytes with %0d bad required 30 with 0 bad", out_data.size(), bad_bytes(120, 29, 1'b0));
        else passed++;
        checks++;
        if (cnt_good !== 4'd4) $display("FAIL stall_good: got %0d required 4", cnt_good);
        else passed++;
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        checks++;
        if ({cnt_good, cnt_err, cnt_drop} !== '0)
            $display("FAIL clr_all: got g=%0d e=%0d d=%0d required 0/0/0", cnt_good, cnt_err, cnt_drop);
        else passed++;
        for (int i = 0; i < 15; i++) run_frame(2, 200 + i, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (cnt_good !== 4'hF) $display("FAIL sat_reach: got %0d required 15", cnt_good);
        else passed++;
        run_frame(2, 7, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (cnt_good !== 4'hF) $display("FAIL sat_hold: got %0d required 15", cnt_good);
        else passed++;
        run_frame(2, 9, 1'b0, 0, 1'b0, 1'b1);
        checks++;
        if (cnt_good !== 4'd0) $display("FAIL clr_priority: got %0d required 0", cnt_good);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        run_frame(3, 44, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (cnt_good !== 4'd1) $display("FAIL pre_rst_good: got %0d required 1", cnt_good);
        else passed++;
        m_tready = 1'b0;
        s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (!(busy === 1'b1 && m_tvalid === 1'b1 && m_tdata === 8'hA5))
            $display("FAIL pre_rst_fwd: got busy=%b v=%b d=%h required 1/1/a5", busy, m_tvalid, m_tdata);
        else passed++;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, busy, cnt_good, cnt_err, cnt_drop} !== '0)
            $display("FAIL rst_mid_frame: got v=%b d=%h rdy=%b busy=%b g=%0d e=%0d dr=%0d required all 0",
                     m_tvalid, m_tdata, s_tready, busy, cnt_good, cnt_err, cnt_drop);
        else passed++;
        s_tvalid = 1'b0; s_tdata = 8'd0;
        @(posedge clk); #1;
        rst = 1'b0; m_tready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_error_frame();
        test_truncate();
        test_parser_abort();
        test_stall();
        test_saturation();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rx_frame_sequencer.md
Name: rx_frame_sequencer

Overview:
- Sits between the RX AXI-Stream FIFO master side and the Ethernet header parser, in the system clock domain.
- Sequences frames one at a time: forwards bytes with backpressure, truncates oversize frames, and drains the remainder of any frame the parser aborts.
- Enforces an inter-frame gap and keeps saturating good/error/drop frame counters for status LEDs and debug.

Parameters:
- MAX_LEN, 1518: maximum bytes forwarded per frame, counting the FCS-stripped bytes as delivered by the FIFO.
- GAP_CYCLES, 4: idle cycles inserted after each frame end before the next frame is accepted. Legal range 0..255.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock; all logic is in this domain.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = accept new frames. Sampled only in IDLE.
- s_tdata  in  8  byte from the FIFO.
- s_tvalid  in  1  FIFO byte valid.
- s_tlast  in  1  last byte of the frame.
- s_tuser  in  1  MAC frame error; meaningful when s_tlast=1.
- s_tready  out  1  consume the FIFO byte.
- m_tdata  out  8  byte to the parser.
- m_tvalid  out  1  output byte valid.
- m_tlast  out  1  last byte forwarded for this frame.
- m_tuser  out  1  frame is bad (MAC error or truncated); valid with m_tlast.
- m_tready  in  1  parser ready.
- parser_err  in  1  single-cycle pulse: parser has aborted the current frame.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_good  out  CNT_W  frames forwarded intact.
- cnt_err  out  CNT_W  frames ending with s_tuser=1.
- cnt_drop  out  CNT_W  frames truncated or aborted by the parser.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - Outputs: m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, s_tready=0, all counters 0, busy=0.
  - Internal byte counter and gap counter cleared.
  - Reset mid-frame abandons the frame; no counter updates.
- Output stage:
  - A single registered stage; latency is 1 cycle from FIFO handshake to m_tvalid.
  - m_* hold stable while m_tvalid=1 and m_tready=0.
- Handshake: a transfer occurs on s_tvalid&&s_tready, or on m_tvalid&&m_tready.
- States:
  - IDLE: s_tready=0. Go to FWD when enable=1 and s_tvalid=1. The byte counter clears on entry.
  - FWD:
    - s_tready = (!m_tvalid || m_tready).
    - Each accepted byte loads the output register and increments the byte counter.
    - Accepted byte with s_tlast=1: m_tlast=1, m_tuser=s_tuser; go to GAP.
    - Accepted byte number MAX_LEN with s_tlast=0: m_tlast=1, m_tuser=1; go to DRAIN; flag the frame as dropped.
    - parser_err=1: clear m_tvalid next cycle regardless of m_tready; flag the frame as dropped. Then go to DRAIN, or to GAP if the FIFO tlast was already accepted.
  - DRAIN:
    - s_tready=1 and m_tvalid=0 after any pending output transfer completes; bytes are discarded.
    - Accepted s_tlast=1: go to GAP.
    - parser_err is ignored.
  - GAP:
    - s_tready=0 for GAP_CYCLES cycles, then go to IDLE.
    - GAP_CYCLES=0: return to IDLE on the next cycle.
    - A pending output byte still completes its m_* handshake during GAP.
- Counter updates occur once per frame, on the cycle the FIFO tlast is accepted:
  - dropped flag set: cnt_drop+1.
  - else s_tuser=1: cnt_err+1.
  - else: cnt_good+1.
  - Exactly one counter increments per frame.
- Counter rules:
  - Counters saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- Simultaneous events:
  - parser_err in the same cycle as the final byte acceptance: the frame counts as dropped, and the state goes to GAP.
  - Truncation at byte MAX_LEN that coincides with s_tlast=1: treated as a normal end, not truncated.
- Enable timing: deasserting enable mid-frame has no effect until IDLE.
- Byte counter width: $clog2(MAX_LEN+1). It never wraps, because truncation occurs at MAX_LEN.

Decomposition:
- Package rx_seq_pkg holds:
  - the state enum (IDLE, FWD, DRAIN, GAP), 2 bits;
  - the constant width function for the byte and gap counters;
  - the frame-result enum (GOOD, ERR, DROP).
- One sub-module, sat_counter (width parameter; inc and clr inputs; clr has priority), instantiated three times.
- The FSM and the output register stay in the top module.

Test Plan:
- Back-to-back 64-byte frames with s_tuser=0, m_tready=1, GAP_CYCLES=4 -> 64 bytes out, each with 1-cycle latency; m_tlast on byte 64; s_tready low for exactly 4 cycles between frames; cnt_good=2.
- 100-byte frame ending with s_tuser=1 -> all 100 bytes forwarded; last byte has m_tlast=1, m_tuser=1; cnt_err=1, cnt_good unchanged.
- MAX_LEN=60, 80-byte frame -> byte 60 carries m_tlast=1, m_tuser=1; bytes 61..80 consumed with m_tvalid=0; cnt_drop=1; next frame forwarded normally.
- parser_err pulse at byte 20 of a 64-byte frame -> m_tvalid=0 from the next cycle; remaining 44 bytes drained; cnt_drop=1; busy=1 until GAP ends.
- m_tready toggled 1,0,0,1 throughout a frame -> m_* held stable while stalled; no byte lost or duplicated; output byte sequence matches input.
- cnt_clr asserted on the same cycle as a good frame end, with cnt_good=0xFFFF -> cnt_good=0. Separately, 0xFFFF plus one more good frame -> stays 0xFFFF. rst asserted mid-FWD -> all outputs 0 immediately.
